fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  - Single-clock UART transmitter draining the read side of the dual-clock gray-pointer FIFO.
//  - Pops one word per frame via a show-ahead interface:
//    - read data valid whenever i_fifo_empty=0;
//    - o_fifo_rd_en advances the pointer.
//  - Serializes each word LSB-first onto o_tx: start bit, data, optional parity, stop bit(s).
//  - Sits in the FIFO read clock domain; i_clk is the FIFO's read clock.
// PARAMETERS
//  DATA_WIDTH    8   bits per frame; must equal the FIFO DATA_WIDTH
//  CLKS_PER_BIT  16  i_clk cycles per serial bit; legal range >= 2
//  STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//  i_clk          in   1           clock (FIFO read clock)
//  i_rst_n        in   1           asynchronous active-low reset
//  i_en           in   1           1 = allowed to start new frames; sampled only in IDLE
//  i_fifo_rdata   in   DATA_WIDTH  FIFO show-ahead read data
//  i_fifo_empty   in   1           FIFO empty flag
//  o_fifo_rd_en   out  1           pop strobe to the FIFO; one-cycle pulse
//  o_tx           out  1           serial line; idles high
//  o_busy         out  1           1 whenever state != IDLE
// BEHAVIOUR
//  Reset:
//   - Async assert forces state=IDLE, o_tx=1, o_busy=0, counters=0, shift reg=0.
//   - o_fifo_rd_en=0 while reset is asserted.
//   - Reset mid-frame truncates the frame; o_tx returns high immediately.
//   - A word popped before reset is lost.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:
//   - o_fifo_rd_en = (state==IDLE) & i_en & ~i_fifo_empty (combinational, never in other states).
//   - On that edge: shift <= i_fifo_rdata, o_tx <= 0, bit counters cleared, state <= START.
//  START: o_tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
//  DATA:
//   - DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
//   - Bit index counter width $clog2(DATA_WIDTH).
//  PARITY: present only with the macro (see CONFIGURATION).
//  STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  Timing and output registers:
//   - o_tx is registered; each bit boundary is an edge where o_tx updates.
//   - Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps at each bit.
//  Frame period:
//   - Pop-to-pop time with the FIFO never empty is F*CLKS_PER_BIT+1 cycles.
//   - F = 1 + DATA_WIDTH + STOP_BITS (+1 with parity).
//   - The extra cycle is the mandatory single IDLE cycle between frames.
//  Boundary rules:
//   - i_en deasserted mid-frame: the current frame completes; no new pop.
//   - i_fifo_empty rising mid-frame: ignored.
//   - i_fifo_rdata changes after the pop: ignored, since data is latched at the pop edge.
//   - Empty FIFO in IDLE: o_tx stays 1 and o_fifo_rd_en stays 0 indefinitely.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   - PARITY state is inserted after DATA for CLKS_PER_BIT cycles.
//   - o_tx = ^data (even parity: total ones in data+parity is even).
//   - Parity is computed from the latched word.
//  UART_PARITY_EN undefined:
//   - No PARITY state and no parity logic; DATA goes directly to STOP.
// TESTING (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless noted)
//  1. Reset with FIFO non-empty -> o_tx=1, o_busy=0, o_fifo_rd_en=0 during reset; first pop on the first edge after release with i_en=1.
//  2. Single word 0xA5 -> one rd_en pulse; o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; then IDLE.
//  3. Words 0x00 then 0xFF queued -> two pops exactly 41 cycles apart; o_tx high for exactly 5 cycles between the frames (4-cycle stop bit plus 1 IDLE cycle).
//  4. i_en=0 with FIFO non-empty for 100 cycles -> no pop, o_tx=1; deassert i_en mid-frame -> the frame completes and no further pop occurs.
//  5. Assert reset at cycle 10 of a 0x3C frame -> o_tx=1 and o_busy=0 asynchronously; after release the next FIFO word starts cleanly.
//  6. UART_PARITY_EN, word 0x07 -> parity bit 1 after bit 7; pop spacing 45 cycles; with STOP_BITS=2 the stop phase lasts 8 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: one pop per frame, LSB-first, registered o_tx.
// Latency: pop edge drives the start bit; frames are spaced by one IDLE cycle. Optional parity: UART_PARITY_EN.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic                    stop_idx;
    logic [DATA_WIDTH-1:0]   shift;
`ifdef UART_PARITY_EN
    logic                    parity;
`endif
    logic                    pop;
    logic                    bit_end;

    // Gating with reset keeps the pop strobe low while the FSM is held in IDLE by reset.
    assign pop          = (state == IDLE) & i_en & ~i_fifo_empty & i_rst_n;
    assign o_fifo_rd_en = pop;
    assign bit_end      = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
`ifdef UART_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= i_fifo_rdata;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        o_tx     <= shift[0];
`ifdef UART_PARITY_EN
                        parity   <= ^shift;
`endif
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            o_tx  <= parity;
                            state <= PARITY;
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        o_tx     <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
